// File: rtl/mc_control.sv
// Multi-cycle Moore control unit for the lab CPU: sequences the shared datapath
// through fetch/decode/execute/memory/write-back and counts retired instructions.
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [5:0]       Op,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstRet
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             op_legal;
    logic             retire;

    // Raw strobes before reset gating
    logic pc_write_raw, mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw;

    assign op_legal = (Op == OP_RTYPE) || (Op == OP_LW) || (Op == OP_SW) ||
                      (Op == OP_BEQ)   || (Op == OP_J)  || (Op == OP_ADDI);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    assign retire = (state_q == S_MEMWB)  || (state_q == S_MEMWR) ||
                    (state_q == S_RWB)    || (state_q == S_BRANCH) ||
                    (state_q == S_JUMP)   || (state_q == S_ADDIWB);

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        reg_write_raw = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b01;
                pc_write_raw = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                mem_read_raw = 1'b1;
                IorD         = 1'b1;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                MemtoReg      = 1'b1;
            end
            S_MEMWR: begin
                mem_write_raw = 1'b1;
                IorD          = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                reg_write_raw = 1'b1;
                RegDst        = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                pc_write_raw = 1'b1;
                PCSource     = 2'b10;
            end
            S_ADDIWB: reg_write_raw = 1'b1;
            default: ;
        endcase
    end

    // Strobes are held low for the whole reset pulse, not just after the next edge
    assign PCWrite   = pc_write_raw  & ~RESET;
    assign MemRead   = mem_read_raw  & ~RESET;
    assign MemWrite  = mem_write_raw & ~RESET;
    assign IRWrite   = ir_write_raw  & ~RESET;
    assign RegWrite  = reg_write_raw & ~RESET;
    assign PCEn      = (pc_write_raw | (PCWriteCond & Zero)) & ~RESET;
    assign IllegalOp = (state_q == S_DECODE) & ~op_legal & ~RESET;
    assign State     = state_q;
    assign InstRet   = instret_q;

endmodule
